// File: rtl/mem_pulse_pkg.sv
// Shared definitions for the memristor pulse sequencer: FSM state encoding
// and default parameter values.
package mem_pulse_pkg;

    localparam int DEF_NCH    = 3;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_TIME_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mem_phase_timer.sv
// Loadable down-counter timing one HIGH or LOW phase; expire_o flags the
// last clock of the phase.
module mem_phase_timer #(
    parameter int TIME_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [TIME_W-1:0] load_val_i,
    output logic              expire_o
);

    logic [TIME_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - TIME_W'(1);
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/mem_pulse_seq.sv
// Memristor pulse-train sequencer: emits num_pulses pulses of high_cycles on
// the masked channels, separated (and terminated) by low_cycles gaps.
module mem_pulse_seq
    import mem_pulse_pkg::*;
#(
    parameter int NCH    = DEF_NCH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int TIME_W = DEF_TIME_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [NCH-1:0]    ch_mask,
    input  logic [CNT_W-1:0]  num_pulses,
    input  logic [TIME_W-1:0] high_cycles,
    input  logic [TIME_W-1:0] low_cycles,
    output logic [NCH-1:0]    pulse_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pulse_count
);

    state_e            state_q, state_d;
    logic [NCH-1:0]    mask_q, mask_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [TIME_W-1:0] high_q, high_d;
    logic [TIME_W-1:0] low_q, low_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0]    pulse_out_q, pulse_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tmr_load;
    logic [TIME_W-1:0] tmr_val;
    logic              tmr_expire;

    // Timer reload value: a phase of D clocks (D=0 treated as 1) loads D-1.
    function automatic logic [TIME_W-1:0] phase_load(input logic [TIME_W-1:0] dur);
        return (dur == '0) ? '0 : dur - TIME_W'(1);
    endfunction

    mem_phase_timer #(
        .TIME_W (TIME_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        num_d    = num_q;
        high_d   = high_q;
        low_d    = low_q;
        cnt_d    = cnt_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d = ch_mask;
                    num_d  = num_pulses;
                    high_d = high_cycles;
                    low_d  = low_cycles;
                    cnt_d  = '0;
                    if (num_pulses != '0) begin
                        state_d  = S_HIGH;
                        tmr_load = 1'b1;
                        tmr_val  = phase_load(high_cycles);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_HIGH: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (tmr_expire) begin
                    state_d  = S_LOW;
                    cnt_d    = cnt_q + CNT_W'(1);
                    tmr_load = 1'b1;
                    tmr_val  = phase_load(low_q);
                end
            end
            S_LOW: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (tmr_expire) begin
                    if (cnt_q < num_q) begin
                        state_d  = S_HIGH;
                        tmr_load = 1'b1;
                        tmr_val  = phase_load(high_q);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        pulse_out_d = (state_d == S_HIGH) ? mask_d : '0;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            num_q       <= '0;
            high_q      <= '0;
            low_q       <= '0;
            cnt_q       <= '0;
            pulse_out_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            num_q       <= num_d;
            high_q      <= high_d;
            low_q       <= low_d;
            cnt_q       <= cnt_d;
            pulse_out_q <= pulse_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pulse_out   = pulse_out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pulse_count = cnt_q;

endmodule

// File: tb/tb_mem_pulse_seq.sv
// Directed and randomized checks of mem_pulse_seq against a cycle-offset
// arithmetic model of the pulse train.
module tb_mem_pulse_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [2:0] ch_mask;
    logic [7:0] num_pulses;
    logic [7:0] high_cycles;
    logic [7:0] low_cycles;
    logic [2:0] pulse_out;
    logic       busy;
    logic       done;
    logic [7:0] pulse_count;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [2:0] pulse;
        logic       busy;
        logic       done;
        logic [7:0] count;
    } exp_t;

    mem_pulse_seq #(
        .NCH    (3),
        .CNT_W  (8),
        .TIME_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .ch_mask     (ch_mask),
        .num_pulses  (num_pulses),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .pulse_count (pulse_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected outputs k cycles after the start cycle, from the pulse-train rules.
    function automatic exp_t model(input int k, input logic [2:0] m,
                                   input int n, input int h, input int l);
        exp_t r;
        int he, le, p, idx, ph;
        he = (h == 0) ? 1 : h;
        le = (l == 0) ? 1 : l;
        p  = he + le;
        r  = '0;
        if (n == 0) begin
            if (k == 1) begin
                r.busy = 1'b1;
                r.done = 1'b1;
            end
        end else if (k <= n * p) begin
            idx     = (k - 1) / p;
            ph      = (k - 1) % p;
            r.pulse = (ph < he) ? m : 3'b000;
            r.busy  = 1'b1;
            r.count = 8'(idx + ((ph >= he) ? 1 : 0));
        end else if (k == n * p + 1) begin
            r.busy  = 1'b1;
            r.done  = 1'b1;
            r.count = 8'(n);
        end else begin
            r.count = 8'(n);
        end
        return r;
    endfunction

    task automatic check_outs(input string tag, input exp_t e);
        check({tag, ".pulse_out"},   int'(pulse_out),   int'(e.pulse));
        check({tag, ".busy"},        int'(busy),        int'(e.busy));
        check({tag, ".done"},        int'(done),        int'(e.done));
        check({tag, ".pulse_count"}, int'(pulse_count), int'(e.count));
    endtask

    // Start a sequence and check every cycle until two cycles after it ends.
    // abort_at/rst_at: cycle offset in which abort/rst is held (0 = never).
    task automatic run_seq(input string tag, input logic [2:0] m, input int n,
                           input int h, input int l, input int abort_at,
                           input int rst_at, input bit noise);
        int he, le, len, stop_k, cut_k;
        logic [7:0] hold;
        exp_t e;
        he     = (h == 0) ? 1 : h;
        le     = (l == 0) ? 1 : l;
        len    = (n == 0) ? 1 : n * (he + le) + 1;
        stop_k = len + 2;
        cut_k  = 0;
        hold   = '0;
        ch_mask     = m;
        num_pulses  = 8'(n);
        high_cycles = 8'(h);
        low_cycles  = 8'(l);
        start       = 1'b1;
        for (int k = 1; k <= stop_k; k++) begin
            step();
            abort = 1'b0;
            rst   = 1'b0;
            if (noise && k < len && (cut_k == 0)) begin
                start       = 1'($urandom_range(0, 1));
                ch_mask     = 3'($urandom);
                num_pulses  = 8'($urandom);
                high_cycles = 8'($urandom);
                low_cycles  = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            if (cut_k != 0 && k >= cut_k) begin
                e       = '0;
                e.count = hold;
            end else begin
                e = model(k, m, n, h, l);
            end
            check_outs($sformatf("%s@%0d", tag, k), e);
            if (k == abort_at) begin
                abort  = 1'b1;
                start  = 1'b0;
                hold   = e.count;
                cut_k  = k + 1;
                stop_k = k + 3;
            end
            if (k == rst_at) begin
                rst    = 1'b1;
                start  = 1'b0;
                hold   = '0;
                cut_k  = k + 1;
                stop_k = k + 3;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        int n, h, l, p, ab;
        logic [2:0] m;

        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        ch_mask     = '0;
        num_pulses  = '0;
        high_cycles = '0;
        low_cycles  = '0;
        step();
        step();
        check_outs("reset", exp_t'('0));
        rst = 1'b0;
        step();
        check_outs("idle_after_reset", exp_t'('0));

        // abort while idle must not disturb anything
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_outs("abort_idle", exp_t'('0));

        run_seq("basic",     3'b101, 3, 2, 1, 0, 0, 1'b0);
        run_seq("n_zero",    3'b111, 0, 2, 1, 0, 0, 1'b0);
        run_seq("zero_dur",  3'b011, 2, 0, 0, 0, 0, 1'b0);
        run_seq("abort_h2",  3'b110, 4, 3, 2, 7, 0, 1'b0);
        run_seq("mid_noise", 3'b101, 3, 2, 1, 0, 0, 1'b1);
        run_seq("mask_zero", 3'b000, 2, 1, 2, 0, 0, 1'b0);
        run_seq("rst_low",   3'b101, 3, 2, 1, 0, 3, 1'b0);
        run_seq("after_rst", 3'b101, 3, 2, 1, 0, 0, 1'b0);
        run_seq("max_n",     3'b010, 255, 0, 0, 0, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            m  = 3'($urandom);
            n  = $urandom_range(0, 6);
            h  = $urandom_range(0, 4);
            l  = $urandom_range(0, 4);
            p  = ((h == 0) ? 1 : h) + ((l == 0) ? 1 : l);
            ab = 0;
            if (n != 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, n * p);
            run_seq($sformatf("rnd%0d", i), m, n, h, l, ab, 0, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
